mem_port_arbiter: RTL and testbench

- Shares one SRAM-like memory port (req/addr_ok/data_ok handshake) between the instruction-fetch requester (IF stage) and the data requester (EXE/MEM stages).
- Sits between the pipeline stages and the single bus bridge to external memory.
- Locks the grant while a request is waiting for address acceptance.
- Tracks in-order outstanding transactions in a small ID FIFO and routes each data_ok/rdata back to the requester that owns it.

---
 rtl/mem_port_arbiter_pkg.sv | 9 +
 rtl/mem_port_arbiter_id.sv | 48 ++++
 rtl/mem_port_arbiter.sv | 96 +++++++++
 tb/tb_mem_port_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared encodings for the memory port arbiter
package mem_port_arbiter_pkg;
    localparam logic SRC_INST = 1'b0;
    localparam logic SRC_DATA = 1'b1;
    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;
    typedef enum logic [1:0] {ST_IDLE, ST_HOLD_I, ST_HOLD_D} state_e;
endpackage

// File: rtl/mem_port_arbiter_id.sv
// arb_id_fifo: in-order owner-ID queue for outstanding memory transactions
module arb_id_fifo #(
    parameter int DEPTH = 2,
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          push,
    input  logic          push_id,
    input  logic          pop,
    output logic          head_id,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);
    logic [DEPTH-1:0] mem_q;
    logic [PW-1:0]    wr_q, rd_q;
    logic [CW-1:0]    cnt_q;
    logic             push_ok, pop_ok;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    assign full    = cnt_q == CW'(DEPTH);
    assign empty   = cnt_q == '0;
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head_id = mem_q[rd_q];
    assign count   = cnt_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_q <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_q] <= push_id;
                wr_q        <= inc(wr_q);
            end
            if (pop_ok) rd_q <= inc(rd_q);
            if (push_ok != pop_ok) cnt_q <= push_ok ? cnt_q + 1'b1 : cnt_q - 1'b1;
        end
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one SRAM-like port between instruction and data requesters
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAX_OUTS = 2,
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_addr_ok,
    output logic          i_data_ok,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_wr,
    input  logic [1:0]    d_size,
    input  logic [3:0]    d_wstrb,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_addr_ok,
    output logic          d_data_ok,
    output logic [DW-1:0] d_rdata,
    output logic          m_req,
    output logic          m_wr,
    output logic [1:0]    m_size,
    output logic [3:0]    m_wstrb,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic          m_addr_ok,
    input  logic          m_data_ok,
    input  logic [DW-1:0] m_rdata,
    output logic          arb_err
);
    localparam int CW = $clog2(MAX_OUTS + 1);

    state_e        state_q, state_d;
    logic          sel, accept, pop, full, empty, head_id, err_q, err_d;
    logic [CW-1:0] count;

    // Data wins in IDLE; a HOLD state pins the choice until the address is taken.
    assign sel       = state_q == ST_HOLD_D || (state_q == ST_IDLE && d_req);
    assign m_req     = (sel ? d_req : i_req) && !full;
    assign accept    = m_req && m_addr_ok;
    assign i_addr_ok = accept && sel == SRC_INST;
    assign d_addr_ok = accept && sel == SRC_DATA;
    assign m_wr      = sel && d_wr;
    assign m_size    = sel ? d_size : SIZE_WORD;
    assign m_wstrb   = sel ? d_wstrb : '0;
    assign m_addr    = sel ? d_addr : i_addr;
    assign m_wdata   = sel ? d_wdata : '0;

    assign pop       = m_data_ok && !empty;
    assign i_data_ok = pop && head_id == SRC_INST;
    assign d_data_ok = pop && head_id == SRC_DATA;
    assign i_rdata   = i_data_ok ? m_rdata : '0;
    assign d_rdata   = d_data_ok ? m_rdata : '0;
    assign arb_err   = err_q;

    always_comb begin
        state_d = state_q;
        err_d   = err_q || (m_data_ok && empty);
        if (m_req && !m_addr_ok) state_d = sel ? ST_HOLD_D : ST_HOLD_I;
        else if (accept) state_d = ST_IDLE;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    arb_id_fifo #(.DEPTH(MAX_OUTS)) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .push    (accept),
        .push_id (sel),
        .pop     (pop),
        .head_id (head_id),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    // Requesters keep req and payload steady until their addr_ok.
    a_i_hold: assert property (@(posedge clk) disable iff (!resetn)
        i_req && !i_addr_ok |=> i_req && $stable(i_addr));
    a_d_hold: assert property (@(posedge clk) disable iff (!resetn)
        d_req && !d_addr_ok |=> d_req && $stable({d_wr, d_size, d_wstrb, d_addr, d_wdata}));
    a_count: assert property (@(posedge clk) disable iff (!resetn) count <= CW'(MAX_OUTS));
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scenario tasks plus an owner-ID scoreboard for responses
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    logic        clk = 0, resetn = 0;
    logic        i_req = 0, d_req = 0, d_wr = 0;
    logic [31:0] i_addr = 0, d_addr = 0, d_wdata = 0, m_rdata = 0;
    logic [1:0]  d_size = 0;
    logic [3:0]  d_wstrb = 0;
    logic        m_addr_ok = 0, m_data_ok = 0;
    logic        i_addr_ok, i_data_ok, d_addr_ok, d_data_ok, m_req, m_wr, arb_err;
    logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
    logic [1:0]  m_size;
    logic [3:0]  m_wstrb;

    int   checks = 0, errors = 0;
    logic exp_q[$];
    logic mon_own, mon_ei, mon_ed;
    logic [31:0] mon_ir, mon_dr;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MAX_OUTS(2), .AW(32), .DW(32)) dut (
        .clk(clk), .resetn(resetn),
        .i_req(i_req), .i_addr(i_addr), .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok), .i_rdata(i_rdata),
        .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_wstrb(d_wstrb), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_wstrb(m_wstrb), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata), .arb_err(arb_err)
    );

    // Response scoreboard: each accept pushes its expected owner; responses pop it.
    always @(negedge clk) begin
        #3;
        if (resetn && (m_data_ok || i_data_ok || d_data_ok)) begin
            checks++;
            mon_ei = 0;
            mon_ed = 0;
            if (exp_q.size() != 0 && m_data_ok) begin
                mon_own = exp_q.pop_front();
                mon_ei  = mon_own == SRC_INST;
                mon_ed  = mon_own == SRC_DATA;
            end
            mon_ir = mon_ei ? m_rdata : 32'h0;
            mon_dr = mon_ed ? m_rdata : 32'h0;
            if ({i_data_ok, d_data_ok, i_rdata, d_rdata} !== {mon_ei, mon_ed, mon_ir, mon_dr}) begin
                errors++;
                $display("FAIL resp got i_ok=%b d_ok=%b i_rdata=%h d_rdata=%h exp i_ok=%b d_ok=%b i_rdata=%h d_rdata=%h",
                         i_data_ok, d_data_ok, i_rdata, d_rdata, mon_ei, mon_ed, mon_ir, mon_dr);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        resetn = 0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({i_addr_ok, d_addr_ok, i_data_ok, d_data_ok, m_req, arb_err} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b exp 000000", {i_addr_ok, d_addr_ok, i_data_ok, d_data_ok, m_req, arb_err});
        end
        resetn = 1;
        @(negedge clk);
    endtask

    task automatic test_inst_only;
        i_req = 1; i_addr = 32'h1C00_0000; m_addr_ok = 1;
        #1;
        checks++;
        if ({m_req, i_addr_ok, d_addr_ok} !== 3'b110) begin
            errors++; $display("FAIL inst_accept got %b exp 110", {m_req, i_addr_ok, d_addr_ok});
        end
        checks++;
        if ({m_addr, m_wr, m_size, m_wstrb} !== {32'h1C00_0000, 1'b0, SIZE_WORD, 4'h0}) begin
            errors++; $display("FAIL inst_payload got %h exp %h", {m_addr, m_wr, m_size, m_wstrb}, {32'h1C00_0000, 1'b0, SIZE_WORD, 4'h0});
        end
        exp_q.push_back(SRC_INST);
        tick;
        i_req = 0; m_addr_ok = 0; m_data_ok = 1; m_rdata = 32'hDEAD_BEEF;
        tick;
        m_data_ok = 0; m_rdata = 0;
    endtask

    task automatic test_priority;
        i_req = 1; i_addr = 32'h1C00_0100;
        d_req = 1; d_wr = 1; d_size = SIZE_WORD; d_wstrb = 4'hF; d_addr = 32'h0000_0040; d_wdata = 32'hCAFE_F00D;
        m_addr_ok = 1;
        #1;
        checks++;
        if ({i_addr_ok, d_addr_ok} !== 2'b01) begin
            errors++; $display("FAIL prio_d_first got %b exp 01", {i_addr_ok, d_addr_ok});
        end
        checks++;
        if ({m_addr, m_wr, m_wdata, m_wstrb} !== {32'h0000_0040, 1'b1, 32'hCAFE_F00D, 4'hF}) begin
            errors++; $display("FAIL prio_d_payload got %h exp %h", {m_addr, m_wr, m_wdata, m_wstrb}, {32'h0000_0040, 1'b1, 32'hCAFE_F00D, 4'hF});
        end
        exp_q.push_back(SRC_DATA);
        tick;
        d_req = 0;
        #1;
        checks++;
        if ({i_addr_ok, d_addr_ok} !== 2'b10) begin
            errors++; $display("FAIL prio_i_second got %b exp 10", {i_addr_ok, d_addr_ok});
        end
        checks++;
        if ({m_addr, m_wr, m_size, m_wstrb} !== {32'h1C00_0100, 1'b0, SIZE_WORD, 4'h0}) begin
            errors++; $display("FAIL prio_i_payload got %h exp %h", {m_addr, m_wr, m_size, m_wstrb}, {32'h1C00_0100, 1'b0, SIZE_WORD, 4'h0});
        end
        exp_q.push_back(SRC_INST);
        tick;
        i_req = 0; m_addr_ok = 0; m_data_ok = 1; m_rdata = 32'h1111_1111;
        tick;
        m_rdata = 32'h2222_2222;
        tick;
        m_data_ok = 0; m_rdata = 0;
    endtask

    task automatic test_hold;
        i_req = 1; i_addr = 32'h1C00_0200; m_addr_ok = 0;
        #1;
        checks++;
        if ({m_req, i_addr_ok, m_addr} !== {1'b1, 1'b0, 32'h1C00_0200}) begin
            errors++; $display("FAIL hold_c0 got %h exp %h", {m_req, i_addr_ok, m_addr}, {1'b1, 1'b0, 32'h1C00_0200});
        end
        tick;
        d_req = 1; d_wr = 0; d_size = SIZE_BYTE; d_wstrb = 4'h0; d_addr = 32'h0000_0080; d_wdata = 0;
        for (int c = 1; c < 3; c++) begin
            #1;
            checks++;
            if ({m_addr, i_addr_ok, d_addr_ok} !== {32'h1C00_0200, 2'b00}) begin
                errors++; $display("FAIL hold_c%0d got %h exp %h", c, {m_addr, i_addr_ok, d_addr_ok}, {32'h1C00_0200, 2'b00});
            end
            tick;
        end
        m_addr_ok = 1;
        #1;
        checks++;
        if ({m_addr, i_addr_ok, d_addr_ok} !== {32'h1C00_0200, 2'b10}) begin
            errors++; $display("FAIL hold_c3 got %h exp %h", {m_addr, i_addr_ok, d_addr_ok}, {32'h1C00_0200, 2'b10});
        end
        exp_q.push_back(SRC_INST);
        tick;
        i_req = 0;
        #1;
        checks++;
        if ({m_addr, m_size, i_addr_ok, d_addr_ok} !== {32'h0000_0080, SIZE_BYTE, 2'b01}) begin
            errors++; $display("FAIL hold_c4 got %h exp %h", {m_addr, m_size, i_addr_ok, d_addr_ok}, {32'h0000_0080, SIZE_BYTE, 2'b01});
        end
        exp_q.push_back(SRC_DATA);
        tick;
        d_req = 0; m_addr_ok = 0; m_data_ok = 1; m_rdata = 32'h3333_3333;
        tick;
        m_rdata = 32'h4444_4444;
        tick;
        m_data_ok = 0; m_rdata = 0;
    endtask

    task automatic test_full;
        i_req = 1; m_addr_ok = 1;
        for (int k = 0; k < 2; k++) begin
            i_addr = 32'h1C00_0300 + 32'(4 * k);
            #1;
            checks++;
            if (i_addr_ok !== 1'b1) begin
                errors++; $display("FAIL full_acc%0d got %b exp 1", k, i_addr_ok);
            end
            exp_q.push_back(SRC_INST);
            tick;
        end
        i_addr = 32'h1C00_0308;
        #1;
        checks++;
        if ({m_req, i_addr_ok} !== 2'b00) begin
            errors++; $display("FAIL full_block got %b exp 00", {m_req, i_addr_ok});
        end
        tick;
        m_data_ok = 1; m_rdata = 32'h5555_5555;
        #1;
        checks++;
        if ({m_req, i_addr_ok} !== 2'b00) begin
            errors++; $display("FAIL full_pop_no_push got %b exp 00", {m_req, i_addr_ok});
        end
        tick;
        m_data_ok = 0;
        #1;
        checks++;
        if ({m_req, i_addr_ok} !== 2'b11) begin
            errors++; $display("FAIL full_reenable got %b exp 11", {m_req, i_addr_ok});
        end
        exp_q.push_back(SRC_INST);
        tick;
        i_req = 0; m_addr_ok = 0; m_data_ok = 1; m_rdata = 32'h6666_6666;
        tick;
        m_rdata = 32'h7777_7777;
        tick;
        m_data_ok = 0; m_rdata = 0;
        checks++;
        if (arb_err !== 1'b0) begin
            errors++; $display("FAIL no_err got %b exp 0", arb_err);
        end
    endtask

    task automatic test_arb_err;
        m_data_ok = 1; m_rdata = 32'h0000_0099;
        tick;
        m_data_ok = 0; m_rdata = 0;
        #1;
        checks++;
        if (arb_err !== 1'b1) begin
            errors++; $display("FAIL err_set got %b exp 1", arb_err);
        end
        tick;
        tick;
        #1;
        checks++;
        if (arb_err !== 1'b1) begin
            errors++; $display("FAIL err_sticky got %b exp 1", arb_err);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        i_req = 1; i_addr = 32'h1C00_0400; m_addr_ok = 1;
        exp_q.push_back(SRC_INST);
        tick;
        exp_q.push_back(SRC_INST);
        tick;
        #1;
        checks++;
        if (m_req !== 1'b0) begin
            errors++; $display("FAIL mid_full got %b exp 0", m_req);
        end
        #1;
        resetn = 0;
        exp_q.delete();
        #1;
        checks++;
        if ({m_req, i_addr_ok, arb_err} !== 3'b110) begin
            errors++; $display("FAIL mid_reset_clear got %b exp 110", {m_req, i_addr_ok, arb_err});
        end
        @(negedge clk);
        resetn = 1;
        #1;
        checks++;
        if (i_addr_ok !== 1'b1) begin
            errors++; $display("FAIL mid_after_accept got %b exp 1", i_addr_ok);
        end
        exp_q.push_back(SRC_INST);
        tick;
        i_req = 0; m_addr_ok = 0; m_data_ok = 1; m_rdata = 32'h1234_5678;
        tick;
        m_data_ok = 0; m_rdata = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset;
        test_inst_only;
        test_priority;
        test_hold;
        test_full;
        test_arb_err;
        test_reset_mid;
        tick;
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL queue_drained got %0d exp 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
